// File: rtl/vga_sync_porch.sv
// VGA output stage: rebuilds position from active-region pulses and
// emits porch-timed active-low syncs with blanked, aligned video.
module vga_sync_porch #(
  parameter int TOTAL_COLS    = 800,
  parameter int TOTAL_ROWS    = 525,
  parameter int ACTIVE_COLS   = 640,
  parameter int ACTIVE_ROWS   = 480,
  parameter int H_FRONT_PORCH = 18,
  parameter int H_BACK_PORCH  = 50,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_BACK_PORCH  = 33,
  parameter int VIDEO_WIDTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_h_sync,
  input  logic                   in_v_sync,
  input  logic [VIDEO_WIDTH-1:0] in_red,
  input  logic [VIDEO_WIDTH-1:0] in_grn,
  input  logic [VIDEO_WIDTH-1:0] in_blu,
  output logic                   out_h_sync,
  output logic                   out_v_sync,
  output logic [VIDEO_WIDTH-1:0] out_red,
  output logic [VIDEO_WIDTH-1:0] out_grn,
  output logic [VIDEO_WIDTH-1:0] out_blu,
  output logic [11:0]            col,
  output logic [11:0]            row,
  output logic                   locked,
  output logic                   resync_err
);

  localparam logic [11:0] COL_LAST = 12'(TOTAL_COLS - 1);
  localparam logic [11:0] ROW_LAST = 12'(TOTAL_ROWS - 1);
  localparam logic [11:0] COL_ACT  = 12'(ACTIVE_COLS);
  localparam logic [11:0] ROW_ACT  = 12'(ACTIVE_ROWS);
  localparam logic [11:0] HS_LO    = 12'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [11:0] HS_HI    = 12'(TOTAL_COLS - H_BACK_PORCH - 1);
  localparam logic [11:0] VS_LO    = 12'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [11:0] VS_HI    = 12'(TOTAL_ROWS - V_BACK_PORCH - 1);

  typedef enum logic {UNLOCKED, LOCKED} state_t;

  state_t                 state_q, state_d;
  logic                   prev_v_q, prev_v_d;
  logic [11:0]            col1_q, col1_d;
  logic [11:0]            row1_q, row1_d;
  logic                   err1_q, err1_d;
  logic [VIDEO_WIDTH-1:0] red1_q, red1_d;
  logic [VIDEO_WIDTH-1:0] grn1_q, grn1_d;
  logic [VIDEO_WIDTH-1:0] blu1_q, blu1_d;

  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic [VIDEO_WIDTH-1:0] red_q, red_d;
  logic [VIDEO_WIDTH-1:0] grn_q, grn_d;
  logic [VIDEO_WIDTH-1:0] blu_q, blu_d;
  logic [11:0]            col_q, col_d;
  logic [11:0]            row_q, row_d;
  logic                   locked_q, locked_d;
  logic                   err_q, err_d;

  logic                   frame_start;
  logic [11:0]            col_nxt;
  logic [11:0]            row_nxt;
  logic                   lk;
  logic                   vis;

  // Stage 1: edge detect and position tracking
  always_comb begin
    frame_start = in_v_sync & ~prev_v_q;
    col_nxt     = (col1_q == COL_LAST) ? 12'd0 : col1_q + 12'd1;
    row_nxt     = row1_q;
    if (col1_q == COL_LAST) begin
      row_nxt = (row1_q == ROW_LAST) ? 12'd0 : row1_q + 12'd1;
    end
    state_d  = state_q;
    prev_v_d = in_v_sync;
    col1_d   = 12'd0;
    row1_d   = 12'd0;
    err1_d   = 1'b0;
    red1_d   = in_red;
    grn1_d   = in_grn;
    blu1_d   = in_blu;
    unique case (state_q)
      UNLOCKED: begin
        if (frame_start) state_d = LOCKED;
      end
      LOCKED: begin
        if (frame_start) begin
          err1_d = (col_nxt != 12'd0) || (row_nxt != 12'd0);
        end else begin
          col1_d = col_nxt;
          row1_d = row_nxt;
        end
      end
      default: state_d = UNLOCKED;
    endcase
  end

  // Stage 2: sync decode and blanking
  always_comb begin
    lk       = (state_q == LOCKED);
    vis      = lk && (col1_q < COL_ACT) && (row1_q < ROW_ACT);
    hs_d     = !(lk && col1_q >= HS_LO && col1_q <= HS_HI);
    vs_d     = !(lk && row1_q >= VS_LO && row1_q <= VS_HI);
    red_d    = vis ? red1_q : '0;
    grn_d    = vis ? grn1_q : '0;
    blu_d    = vis ? blu1_q : '0;
    col_d    = col1_q;
    row_d    = row1_q;
    locked_d = lk;
    err_d    = err1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= UNLOCKED;
      prev_v_q <= 1'b1;
      col1_q   <= '0;
      row1_q   <= '0;
      err1_q   <= 1'b0;
      red1_q   <= '0;
      grn1_q   <= '0;
      blu1_q   <= '0;
      hs_q     <= 1'b1;
      vs_q     <= 1'b1;
      red_q    <= '0;
      grn_q    <= '0;
      blu_q    <= '0;
      col_q    <= '0;
      row_q    <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_v_q <= prev_v_d;
      col1_q   <= col1_d;
      row1_q   <= row1_d;
      err1_q   <= err1_d;
      red1_q   <= red1_d;
      grn1_q   <= grn1_d;
      blu1_q   <= blu1_d;
      hs_q     <= hs_d;
      vs_q     <= vs_d;
      red_q    <= red_d;
      grn_q    <= grn_d;
      blu_q    <= blu_d;
      col_q    <= col_d;
      row_q    <= row_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  assign out_h_sync = hs_q;
  assign out_v_sync = vs_q;
  assign out_red    = red_q;
  assign out_grn    = grn_q;
  assign out_blu    = blu_q;
  assign col        = col_q;
  assign row        = row_q;
  assign locked     = locked_q;
  assign resync_err = err_q;

endmodule
